axi_crossbar_bresp_router: RTL and testbench

//  Return path for the crossbar write channel. Records the one-hot arbiter grant of each

---
 rtl/axi_crossbar_bresp_router.sv | 111 +++++++++++
 tb/tb_axi_crossbar_bresp_router.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_bresp_router.sv
// Write-response return path: remembers the one-hot grant of every accepted AW in order
// and steers each slave B response back to the master that issued the matching write.
module axi_crossbar_bresp_router #(
  parameter int AXI_REQUEST_NUM = 3,
  parameter int OUTSTANDING_NUM = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               grant_valid_i,
  input  logic [AXI_REQUEST_NUM-1:0]         grant_i,
  output logic                               grant_ready_o,
  input  logic                               s_bvalid_i,
  input  logic [1:0]                         s_bresp_i,
  output logic                               s_bready_o,
  output logic [AXI_REQUEST_NUM-1:0]         m_bvalid_o,
  output logic [1:0]                         m_bresp_o,
  input  logic [AXI_REQUEST_NUM-1:0]         m_bready_i,
  output logic [$clog2(OUTSTANDING_NUM):0]   outstanding_o,
  output logic                               err_grant_o
);

  localparam int N  = AXI_REQUEST_NUM;
  localparam int PW = $clog2(OUTSTANDING_NUM);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING_NUM);

  logic [N-1:0]  fifo_q [OUTSTANDING_NUM];
  logic [N-1:0]  fifo_d [OUTSTANDING_NUM];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_dest_q, rsp_dest_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
  logic          err_q, err_d;

  logic grant_onehot;
  logic fifo_empty;
  logic out_done;
  logic push;
  logic pop;

  // A slot freed by a same-cycle pop is deliberately not reusable until the next cycle.
  assign grant_onehot  = (grant_i != '0) && ((grant_i & (grant_i - N'(1))) == '0);
  assign grant_ready_o = (count_q != FULL_CNT);
  assign fifo_empty    = (count_q == '0);
  assign out_done      = rsp_valid_q & |(m_bready_i & rsp_dest_q);
  assign s_bready_o    = !fifo_empty & (!rsp_valid_q | out_done);
  assign push          = grant_valid_i & grant_ready_o & grant_onehot;
  assign pop           = s_bvalid_i & s_bready_o;

  assign m_bvalid_o    = rsp_dest_q & {N{rsp_valid_q}};
  assign m_bresp_o     = rsp_resp_q;
  assign outstanding_o = count_q;
  assign err_grant_o   = err_q;

  always_comb begin
    for (int i = 0; i < OUTSTANDING_NUM; i++) fifo_d[i] = fifo_q[i];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dest_d  = rsp_dest_q;
    rsp_resp_d  = rsp_resp_q;
    err_d       = err_q | (grant_valid_i & !grant_onehot);

    if (push) begin
      fifo_d[wr_ptr_q] = grant_i;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    // A new pop overwrites the register; otherwise an accepted response empties it.
    if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_dest_d  = fifo_q[rd_ptr_q];
      rsp_resp_d  = s_bresp_i;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end else if (out_done) begin
      rsp_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < OUTSTANDING_NUM; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dest_q  <= '0;
      rsp_resp_q  <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < OUTSTANDING_NUM; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dest_q  <= rsp_dest_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_crossbar_bresp_router.sv
// Directed bench for axi_crossbar_bresp_router (3 masters, 4 outstanding writes):
// ordering, full, backpressure, empty race, bad grants and mid-burst reset.
module tb_axi_crossbar_bresp_router;

  logic       ACLK;
  logic       ARESETN;
  logic       grant_valid_i;
  logic [2:0] grant_i;
  logic       grant_ready_o;
  logic       s_bvalid_i;
  logic [1:0] s_bresp_i;
  logic       s_bready_o;
  logic [2:0] m_bvalid_o;
  logic [1:0] m_bresp_o;
  logic [2:0] m_bready_i;
  logic [2:0] outstanding_o;
  logic       err_grant_o;

  int total_checks;
  int failed_checks;

  axi_crossbar_bresp_router #(
    .AXI_REQUEST_NUM(3),
    .OUTSTANDING_NUM(4)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .grant_valid_i (grant_valid_i),
    .grant_i       (grant_i),
    .grant_ready_o (grant_ready_o),
    .s_bvalid_i    (s_bvalid_i),
    .s_bresp_i     (s_bresp_i),
    .s_bready_o    (s_bready_o),
    .m_bvalid_o    (m_bvalid_o),
    .m_bresp_o     (m_bresp_o),
    .m_bready_i    (m_bready_i),
    .outstanding_o (outstanding_o),
    .err_grant_o   (err_grant_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Drives all stimulus inputs, then waits for combinational outputs to settle.
  task automatic applyStimulus(input logic gv, input logic [2:0] g, input logic sv,
                               input logic [1:0] sr, input logic [2:0] mr);
    grant_valid_i = gv;
    grant_i       = g;
    s_bvalid_i    = sv;
    s_bresp_i     = sr;
    m_bready_i    = mr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks every status output in one call.
  task automatic checkAll(input string tag, input logic [2:0] mv, input logic [1:0] mr,
                          input logic sb, input logic gr, input logic [2:0] cnt,
                          input logic err);
    checkOutput({tag, " m_bvalid"}, 32'(m_bvalid_o), 32'(mv));
    checkOutput({tag, " m_bresp"}, 32'(m_bresp_o), 32'(mr));
    checkOutput({tag, " s_bready"}, 32'(s_bready_o), 32'(sb));
    checkOutput({tag, " grant_ready"}, 32'(grant_ready_o), 32'(gr));
    checkOutput({tag, " outstanding"}, 32'(outstanding_o), 32'(cnt));
    checkOutput({tag, " err_grant"}, 32'(err_grant_o), 32'(err));
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    ARESETN = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b000);
    tick();
    tick();
    checkAll("reset", 3'b000, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    ARESETN = 1'b1;
    tick();

    $display("[TB] order");
    applyStimulus(1'b1, 3'b001, 1'b0, 2'd0, 3'b111);
    tick();
    applyStimulus(1'b1, 3'b100, 1'b0, 2'd0, 3'b111);
    tick();
    applyStimulus(1'b1, 3'b010, 1'b0, 2'd0, 3'b111);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd0, 3'b111);
    checkAll("order pre", 3'b000, 2'd0, 1'b1, 1'b1, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd2, 3'b111);
    checkAll("order b0", 3'b001, 2'd0, 1'b1, 1'b1, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd0, 3'b111);
    checkAll("order b1", 3'b100, 2'd2, 1'b1, 1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b111);
    checkAll("order b2", 3'b010, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    checkAll("order idle", 3'b000, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("[TB] full");
    applyStimulus(1'b1, 3'b001, 1'b0, 2'd0, 3'b000);
    tick();
    applyStimulus(1'b1, 3'b010, 1'b0, 2'd0, 3'b000);
    tick();
    applyStimulus(1'b1, 3'b100, 1'b0, 2'd0, 3'b000);
    tick();
    applyStimulus(1'b1, 3'b001, 1'b0, 2'd0, 3'b000);
    tick();
    applyStimulus(1'b1, 3'b010, 1'b0, 2'd0, 3'b000);
    checkAll("full 4", 3'b000, 2'd0, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    // Pop while full plus a push attempt: the push must still be refused.
    applyStimulus(1'b1, 3'b100, 1'b1, 2'd1, 3'b000);
    checkAll("full 5th ignored", 3'b000, 2'd0, 1'b1, 1'b0, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b000);
    checkAll("full after pop", 3'b001, 2'd1, 1'b0, 1'b1, 3'd3, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd0, 3'b111);
    checkOutput("bp accept s_bready", 32'(s_bready_o), 32'd1);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd3, 3'b101);
    for (int i = 0; i < 3; i++) begin
      checkAll("bp hold", 3'b010, 2'd0, 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd3, 3'b010);
    checkAll("bp release", 3'b010, 2'd0, 1'b1, 1'b1, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd1, 3'b111);
    checkAll("bp next", 3'b100, 2'd3, 1'b1, 1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b111);
    checkAll("bp last", 3'b001, 2'd1, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();

    $display("[TB] empty race");
    applyStimulus(1'b1, 3'b100, 1'b1, 2'd2, 3'b111);
    checkAll("race T", 3'b000, 2'd1, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd2, 3'b111);
    checkAll("race T+1", 3'b000, 2'd1, 1'b1, 1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b111);
    checkAll("race T+2", 3'b100, 2'd2, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();

    $display("[TB] bad grant");
    applyStimulus(1'b1, 3'b011, 1'b0, 2'd0, 3'b111);
    checkOutput("bad before err", 32'(err_grant_o), 32'd0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b111);
    checkAll("bad 011", 3'b000, 2'd2, 1'b0, 1'b1, 3'd0, 1'b1);
    applyStimulus(1'b1, 3'b000, 1'b0, 2'd0, 3'b111);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 2'd0, 3'b111);
    tick();
    checkAll("bad sticky", 3'b000, 2'd2, 1'b0, 1'b1, 3'd0, 1'b1);

    $display("[TB] mid-burst reset");
    applyStimulus(1'b1, 3'b001, 1'b0, 2'd0, 3'b000);
    tick();
    applyStimulus(1'b1, 3'b010, 1'b0, 2'd0, 3'b000);
    tick();
    applyStimulus(1'b1, 3'b100, 1'b1, 2'd3, 3'b000);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd1, 3'b000);
    checkAll("pre reset", 3'b001, 2'd3, 1'b0, 1'b1, 3'd2, 1'b1);
    ARESETN = 1'b0;
    #1;
    checkAll("async reset", 3'b000, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    ARESETN = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b1, 2'd1, 3'b111);
    tick();
    tick();
    checkAll("post reset", 3'b000, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
